but_real_stage_ctrl: RTL and testbench

- Sequences one shared real butterfly (sum/difference with rounding to OUT_W) over an N-point frame held in a dual-port sample memory.
- For each pair index i in 0..N/2-1 it reads samples i and i+N/2, presents them to the butterfly, and writes the sum back to address i and the difference to address i+N/2, in place.
- Sits between the frame buffer and the butterfly datapath. Upstream frame logic starts it with a single start pulse.

---
 rtl/but_real_stage_ctrl.sv | 82 ++++++++
 tb/tb_but_real_stage_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/but_real_stage_ctrl.sv
// but_real_stage_ctrl: sequences one shared real butterfly in place over an N-point frame
// held in a dual-port memory; read -> capture -> write pipeline with global stall.
module but_real_stage_ctrl #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 8,
    parameter int N      = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stall,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr_a,
    output logic [ADDR_W-1:0]        rd_addr_b,
    input  logic signed [IN_W-1:0]   rd_data_a,
    input  logic signed [IN_W-1:0]   rd_data_b,
    output logic signed [IN_W-1:0]   bf_in_a,
    output logic signed [IN_W-1:0]   bf_in_b,
    input  logic signed [OUT_W-1:0]  bf_out_p,
    input  logic signed [OUT_W-1:0]  bf_out_n,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr_a,
    output logic [ADDR_W-1:0]        wr_addr_b,
    output logic signed [OUT_W-1:0]  wr_data_a,
    output logic signed [OUT_W-1:0]  wr_data_b
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t            state;
    logic [ADDR_W-2:0] rc, a1, a2;
    logic              s1_v, s2_v;

    assign busy      = state == RUN || state == DRAIN;
    assign done      = state == FIN && !stall;
    assign rd_en     = state == RUN && !stall;
    assign wr_en     = s2_v && !stall;
    assign rd_addr_a = rd_en ? {1'b0, rc} : '0;
    assign rd_addr_b = rd_en ? {1'b1, rc} : '0;
    assign wr_addr_a = wr_en ? {1'b0, a2} : '0;
    assign wr_addr_b = wr_en ? {1'b1, a2} : '0;
    assign wr_data_a = wr_en ? bf_out_p : '0;
    assign wr_data_b = wr_en ? bf_out_n : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rc      <= '0;
            a1      <= '0;
            a2      <= '0;
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            bf_in_a <= '0;
            bf_in_b <= '0;
        end else begin
            // start is honoured even under stall; the first read then waits for stall to drop
            if (state == IDLE && start) begin
                state <= RUN;
                rc    <= '0;
            end
            if (!stall) begin
                s1_v <= rd_en;
                a1   <= rc;
                s2_v <= s1_v;
                a2   <= a1;
                if (s1_v) begin
                    bf_in_a <= rd_data_a;
                    bf_in_b <= rd_data_b;
                end
                if (state == RUN) begin
                    rc <= rc + 1'b1;
                    if (&rc) state <= DRAIN;
                end
                // stage 2 drains this very cycle, so only stage 1 must already be empty
                if (state == DRAIN && !s1_v) state <= FIN;
                if (state == FIN) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_but_real_stage_ctrl.sv
// tb_but_real_stage_ctrl: directed bench with memory and rounding-butterfly models and
// a write scoreboard filled at read issue and drained at each write.
module tb_but_real_stage_ctrl;
    localparam int IN_W = 8, OUT_W = 8, N = 32, AW = 5, HN = N / 2;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, load = 1'b0;
    logic busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic signed [IN_W-1:0] rd_data_a = '0, rd_data_b = '0, bf_in_a, bf_in_b;
    logic signed [OUT_W-1:0] bf_out_p, bf_out_n, wr_data_a, wr_data_b;
    logic signed [7:0] mem [N];
    logic signed [7:0] init [N];

    typedef struct {int addr; int p; int n;} exp_t;
    exp_t sb [$];
    int rd_q [$];
    int done_q [$];
    int checks = 0, failures = 0, cyc = 0, t0 = 0;
    int wr_n, wr_first, wr_last, busy_n, stall_bad, rd_next;

    but_real_stage_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .N(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .bf_in_a(bf_in_a), .bf_in_b(bf_in_b),
        .bf_out_p(bf_out_p), .bf_out_n(bf_out_n), .wr_en(wr_en),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
    );

    always #5 clk = ~clk;

    // rounding butterfly: halve with round-half-up, saturate to 8 bits
    function automatic int bfr(input int s);
        int r;
        r = (s + 1) >>> 1;
        return r > 127 ? 127 : (r < -128 ? -128 : r);
    endfunction

    assign bf_out_p = 8'(bfr(int'(bf_in_a) + int'(bf_in_b)));
    assign bf_out_n = 8'(bfr(int'(bf_in_a) - int'(bf_in_b)));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) begin
            for (int k = 0; k < N; k++) mem[k] <= init[k];
        end else if (wr_en) begin
            mem[wr_addr_a] <= wr_data_a;
            mem[wr_addr_b] <= wr_data_b;
        end
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rd_en) begin
            rd_q.push_back(cyc - t0);
            chk("rd_addr_a", int'(rd_addr_a), rd_next);
            chk("rd_addr_b", int'(rd_addr_b), rd_next + HN);
            sb.push_back('{rd_next, bfr(int'(mem[rd_next]) + int'(mem[rd_next + HN])),
                          bfr(int'(mem[rd_next]) - int'(mem[rd_next + HN]))});
            rd_next = (rd_next + 1) % HN;
        end
        if (wr_en) begin
            if (wr_n == 0) wr_first = cyc - t0;
            wr_last = cyc - t0;
            wr_n++;
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sb.pop_front();
                chk("wr_addr_a", int'(wr_addr_a), e.addr);
                chk("wr_addr_b", int'(wr_addr_b), e.addr + HN);
                chk("wr_data_a", int'(wr_data_a), e.p);
                chk("wr_data_b", int'(wr_data_b), e.n);
            end
        end
        if (done) done_q.push_back(cyc - t0);
        if (busy) busy_n++;
        if (stall && (rd_en || wr_en)) stall_bad++;
    end

    function automatic int any_out();
        return int'(|{busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b,
                      wr_data_a, wr_data_b, bf_in_a, bf_in_b});
    endfunction

    task automatic reload();
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // cycle 0 is the cycle start is high; the other k arguments are relative to it (-1 = unused)
    task automatic run(input int kmax, input int st_from, input int st_len,
                       input int rp1, input int rp2, input int rst_at);
        rd_q.delete();
        done_q.delete();
        wr_n = 0; busy_n = 0; stall_bad = 0; rd_next = 0;
        t0 = cyc;
        for (int k = 0; k < kmax; k++) begin
            start = (k == 0 || k == rp1 || k == rp2);
            stall = (k >= st_from && k < st_from + st_len);
            rst_n = (k != rst_at);
            if (rst_at >= 0 && k == rst_at + 1) begin
                @(negedge clk);
                chk("outputs_zero_after_reset", any_out(), 0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; stall = 1'b0; rst_n = 1'b1;
    endtask

    task automatic check_mem();
        for (int i = 0; i < HN; i++) begin
            chk("mem_sum", int'(mem[i]), bfr(int'(init[i]) + int'(init[i + HN])));
            chk("mem_diff", int'(mem[i + HN]), bfr(int'(init[i]) - int'(init[i + HN])));
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) init[k] = 8'(k);
        load = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", any_out(), 0);
        @(posedge clk); #1;
        load = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        // plain frame
        run(24, -1, 0, -1, -1, -1);
        chk("reads", rd_q.size(), 16);
        chk("first_read", rd_q[0], 1);
        chk("last_read", rd_q[15], 16);
        chk("writes", wr_n, 16);
        chk("first_write", wr_first, 3);
        chk("last_write", wr_last, 18);
        chk("done_count", done_q.size(), 1);
        chk("done_cycle", done_q.size() > 0 ? done_q[0] : -1, 19);
        chk("busy_cycles", busy_n, 18);
        chk("sb_left", sb.size(), 0);
        check_mem();

        // 3-cycle stall from cycle 5
        reload();
        run(28, 5, 3, -1, -1, -1);
        chk("stall_quiet", stall_bad, 0);
        chk("stall_read5", rd_q.size() > 4 ? rd_q[4] : -1, 8);
        chk("stall_last_read", rd_q.size() > 15 ? rd_q[15] : -1, 19);
        chk("stall_last_write", wr_last, 21);
        chk("stall_done", done_q.size() > 0 ? done_q[0] : -1, 22);
        chk("stall_done_count", done_q.size(), 1);
        chk("stall_busy", busy_n, 21);
        check_mem();

        // start re-pulsed mid-frame
        reload();
        run(26, -1, 0, 4, 10, -1);
        chk("restart_writes", wr_n, 16);
        chk("restart_reads", rd_q.size(), 16);
        chk("restart_done_count", done_q.size(), 1);
        chk("restart_done", done_q.size() > 0 ? done_q[0] : -1, 19);
        check_mem();

        // reset for one cycle at cycle 8, then a clean frame
        reload();
        run(14, -1, 0, -1, -1, 8);
        chk("abort_reads", rd_q.size(), 8);
        chk("abort_done", done_q.size(), 0);
        sb.delete();
        reload();
        run(24, -1, 0, -1, -1, -1);
        chk("post_reset_writes", wr_n, 16);
        chk("post_reset_done", done_q.size() > 0 ? done_q[0] : -1, 19);
        check_mem();

        // extreme values
        for (int k = 0; k < N; k++) init[k] = k < HN ? 8'sd127 : -8'sd128;
        reload();
        run(24, -1, 0, -1, -1, -1);
        chk("extreme_writes", wr_n, 16);
        check_mem();

        // back-to-back frames, second start in the cycle after done
        for (int k = 0; k < N; k++) init[k] = 8'(k);
        reload();
        run(44, -1, 0, 20, -1, -1);
        chk("b2b_done_count", done_q.size(), 2);
        chk("b2b_done1", done_q.size() > 0 ? done_q[0] : -1, 19);
        chk("b2b_done2", done_q.size() > 1 ? done_q[1] : -1, 39);
        chk("b2b_reads", rd_q.size(), 32);
        chk("b2b_second_first_read", rd_q.size() > 16 ? rd_q[16] : -1, 21);
        chk("b2b_writes", wr_n, 32);
        chk("b2b_sb_left", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
